// File: rtl/spi_slave_rx_if.sv
// SPI slave receive port bundle: raw SPI pins plus the received-frame outputs.
interface spi_slave_rx_if #(
    parameter int unsigned DATA_W = 16
);
    logic              spi_cs;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_miso;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              busy;

    // SPI master side: drives the bus, observes the slave's results.
    modport master (
        output spi_cs, spi_clk, spi_mosi,
        input  spi_miso, rx_data, rx_valid, frame_err, busy
    );

    // SPI slave side: samples the bus, presents received frames.
    modport slave (
        input  spi_cs, spi_clk, spi_mosi,
        output spi_miso, rx_data, rx_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver, fully oversampled in the clk_50m domain.
// Captures DATA_W-bit MSB-first frames, pulses rx_valid on a good frame and
// frame_err on a short or overlong one.
// Optional feature macro: SPI_SLAVE_RX_ECHO_EN -- when defined, spi_miso
// shifts out the previous good rx_data during each frame; otherwise it is 0.
module spi_slave_rx #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk_50m,
    input  logic           rst_n,
    spi_slave_rx_if.slave  spi
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic                   cs_prev, sclk_prev;
    logic                   cs_lvl, sclk_lvl, mosi_bit;
    logic                   cs_fall, cs_rise, sclk_rise;

    state_t            state, state_n;
    logic [DATA_W-1:0] sr, sr_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic              overrun, overrun_n;
    logic [DATA_W-1:0] rx_data_q, rx_data_n;
    logic              rx_valid_q, rx_valid_n;
    logic              frame_err_q, frame_err_n;
    logic              busy_q, busy_n;

    // Synchronizer chains plus one edge-detect register for CS and SCK.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
            cs_prev   <= cs_sync[SYNC_STAGES-1];
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_lvl    = cs_sync[SYNC_STAGES-1];
    assign sclk_lvl  = sclk_sync[SYNC_STAGES-1];
    assign mosi_bit  = mosi_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_prev & ~cs_lvl;
    assign cs_rise   = ~cs_prev & cs_lvl;
    assign sclk_rise = ~sclk_prev & sclk_lvl;

    // FSM state, shift datapath and registered outputs.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sr          <= '0;
            bit_cnt     <= '0;
            overrun     <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_n;
            sr          <= sr_n;
            bit_cnt     <= bit_cnt_n;
            overrun     <= overrun_n;
            rx_data_q   <= rx_data_n;
            rx_valid_q  <= rx_valid_n;
            frame_err_q <= frame_err_n;
            busy_q      <= busy_n;
        end
    end

    // Next-state and next-output logic; strobes line up with the DONE cycle.
    always_comb begin
        state_n     = state;
        sr_n        = sr;
        bit_cnt_n   = bit_cnt;
        overrun_n   = overrun;
        rx_data_n   = rx_data_q;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_n = '0;
                overrun_n = 1'b0;
                // Level check also catches a CS fall that landed during DONE.
                if (cs_fall || !cs_lvl) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                // CS rise wins over a coincident SCK rise.
                if (cs_rise) begin
                    state_n = DONE;
                    if ((bit_cnt == CNT_W'(DATA_W)) && !overrun) begin
                        rx_valid_n = 1'b1;
                        rx_data_n  = sr;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end else if (sclk_rise) begin
                    if (bit_cnt < CNT_W'(DATA_W)) begin
                        sr_n      = {sr[DATA_W-2:0], mosi_bit};
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end else begin
                        overrun_n = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n == SHIFT);
    end

    assign spi.rx_data   = rx_data_q;
    assign spi.rx_valid  = rx_valid_q;
    assign spi.frame_err = frame_err_q;
    assign spi.busy      = busy_q;

`ifdef SPI_SLAVE_RX_ECHO_EN
    logic             sclk_fall;
    logic [DATA_W-1:0] tx_sr, tx_sr_n;
    logic [CNT_W-1:0]  tx_cnt, tx_cnt_n;
    logic              miso_q, miso_n;

    assign sclk_fall = sclk_prev & ~sclk_lvl;

    // Echo shifter registers.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr  <= '0;
            tx_cnt <= '0;
            miso_q <= 1'b0;
        end else begin
            tx_sr  <= tx_sr_n;
            tx_cnt <= tx_cnt_n;
            miso_q <= miso_n;
        end
    end

    // Load the last good word at frame start, advance one bit per SCK fall.
    always_comb begin
        tx_sr_n  = tx_sr;
        tx_cnt_n = tx_cnt;
        miso_n   = 1'b0;
        if ((state == IDLE) && (state_n == SHIFT)) begin
            miso_n   = rx_data_q[DATA_W-1];
            tx_sr_n  = {rx_data_q[DATA_W-2:0], 1'b0};
            tx_cnt_n = CNT_W'(1);
        end else if ((state == SHIFT) && (state_n == SHIFT)) begin
            miso_n = miso_q;
            if (sclk_fall) begin
                if (tx_cnt < CNT_W'(DATA_W)) begin
                    miso_n   = tx_sr[DATA_W-1];
                    tx_sr_n  = {tx_sr[DATA_W-2:0], 1'b0};
                    tx_cnt_n = tx_cnt + CNT_W'(1);
                end else begin
                    miso_n = 1'b0;
                end
            end
        end
    end

    assign spi.spi_miso = miso_q;
`else
    assign spi.spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomized scoreboard bench for spi_slave_rx acting as an SPI mode-0 master.
module tb_spi_slave_rx;
    localparam int unsigned DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    spi_slave_rx_if #(.DATA_W(DW)) sif ();

    spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk_50m (clk),
        .rst_n   (rst_n),
        .spi     (sif)
    );

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] model_last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every strobe from the DUT must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (sif.rx_valid || sif.frame_err)) begin
            if (sif.rx_valid && sif.frame_err)
                chk("valid_err_same_cycle", 32'(1), 32'(0));
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'({sif.frame_err, sif.rx_valid}), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_kind", 32'({sif.frame_err, sif.rx_valid}),
                    mon_e.err ? 32'(2) : 32'(1));
                chk("rx_data", 32'(sif.rx_data), 32'(mon_e.data));
            end
        end
    end

    // Send one CS-framed burst of nbits SCK pulses; bits beyond DW are random.
    task automatic send_frame(input int nbits, input logic [DW-1:0] w);
        logic [31:0]   miso_got;
        logic [31:0]   miso_exp;
        logic [DW-1:0] echo;
        logic          eb;
        miso_got = '0;
        miso_exp = '0;
        echo     = model_last;
        @(negedge clk);
        sif.spi_cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            sif.spi_mosi = (i < DW) ? w[DW-1-i] : 1'($urandom);
            repeat (5) @(negedge clk);
`ifdef SPI_SLAVE_RX_ECHO_EN
            eb = (i < DW) ? echo[DW-1-i] : 1'b0;
`else
            eb = 1'b0;
`endif
            miso_got = {miso_got[30:0], sif.spi_miso};
            miso_exp = {miso_exp[30:0], eb};
            sif.spi_clk = 1'b1;
            repeat (5) @(negedge clk);
            sif.spi_clk = 1'b0;
            if (i == 7) chk("busy_mid_frame", 32'(sif.busy), 32'(1));
        end
        repeat (5) @(negedge clk);
        if (nbits == DW) begin
            exp_q.push_back('{err: 1'b0, data: w});
            model_last = w;
        end else begin
            exp_q.push_back('{err: 1'b1, data: model_last});
        end
        sif.spi_cs = 1'b1;
        chk("miso_bits", miso_got, miso_exp);
    endtask

    // Wait (bounded) for all expected strobes, then confirm the slave is idle.
    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'(0));
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        chk("busy_after_frame", 32'(sif.busy), 32'(0));
    endtask

    task automatic check_reset_outputs();
        chk("rst_rx_data", 32'(sif.rx_data), 32'(0));
        chk("rst_rx_valid", 32'(sif.rx_valid), 32'(0));
        chk("rst_frame_err", 32'(sif.frame_err), 32'(0));
        chk("rst_busy", 32'(sif.busy), 32'(0));
        chk("rst_miso", 32'(sif.spi_miso), 32'(0));
    endtask

    initial begin
        int nb;
        sif.spi_cs   = 1'b1;
        sif.spi_clk  = 1'b0;
        sif.spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Directed frames.
        send_frame(16, 16'hA55A);
        drain();
        send_frame(16, 16'h0001);
        repeat (4) @(negedge clk);
        send_frame(16, 16'hFFFF);
        drain();
        send_frame(15, 16'h1357);
        drain();
        send_frame(17, 16'h2468);
        drain();
        send_frame(16, 16'hC3C3);
        drain();
        send_frame(16, 16'h0F0F);
        drain();

        // Reset in the middle of a frame discards it.
        @(negedge clk);
        sif.spi_cs = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sif.spi_mosi = 1'(16'h1234 >> (15 - i));
            repeat (5) @(negedge clk);
            sif.spi_clk = 1'b1;
            repeat (5) @(negedge clk);
            sif.spi_clk = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        sif.spi_cs = 1'b1;
        repeat (5) @(negedge clk);
        rst_n      = 1'b1;
        model_last = '0;
        repeat (5) @(negedge clk);
        send_frame(16, 16'h5678);
        drain();

        // Randomized frames with random lengths and gaps.
        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 3))
                0:       nb = 15;
                1:       nb = 17;
                default: nb = 16;
            endcase
            send_frame(nb, 16'($urandom));
            repeat ($urandom_range(4, 10)) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
